conv_encoder_punct: RTL and testbench
=====================================

# conv_encoder_punct

- Parametrised IEEE 802.11 convolutional encoder (K=7, configurable generators) with rate-dependent puncturing and an output bit packer.
- Per packet it accepts WIDTH-bit scrambled data beats and applies 1/2, 2/3 or 3/4 puncturing, selected by the rate code latched on the first beat.
- It packs the surviving coded bits densely into OUT_WIDTH-bit output words, with no zero gaps between beats.
- It sits between the scrambler and the interleaver in the transmit chain.

## Interface
- WIDTH, 24: input bits per beat; must be a multiple of 6.
- OUT_WIDTH, 48: output word bits; must be ≥ 2*WIDTH.
- G0, 7'o133: generator polynomial A. Bit 6 taps the current input bit; bit k taps the input k bits earlier.
- G1, 7'o171: generator polynomial B, same convention.
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  WIDTH  data bits; bit 0 is earliest in time.
- s_axis_tuser  in  4  rate code (`RATE_*` from ieee80211_defs.v); sampled on the first beat of a packet only.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of the packet.
- m_axis_tdata  out  OUT_WIDTH  coded bits; bit 0 is earliest; unused bits are 0.
- m_axis_tuser  out  4  latched rate code of the packet.
- m_axis_tcount  out  $clog2(OUT_WIDTH+1)  number of valid bits in the word; equals OUT_WIDTH except possibly on the tlast word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of the packet.

## Operation
- **Encoding:** for input bit i, A_i and B_i are the XOR of the taps selected by G0 and G1 over the current bit and the 6-bit history. Unpunctured bit order is A0,B0,A1,B1,...
- **Rate select:**
  - `RATE_6M`/`12M`/`24M` → 1/2: keep all bits; 2*WIDTH bits per beat.
  - `RATE_48M` → 2/3: per 2 input bits keep A0,B0,A1; 3*WIDTH/2 bits per beat.
  - `RATE_9M`/`18M`/`36M`/`54M` → 3/4: per 3 input bits keep A0,B0,A1,B2; 4*WIDTH/3 bits per beat.
  - Any other code → 1/2.
  - The puncture phase restarts at every beat; this is legal because WIDTH is a multiple of 6.
- **Rate latching:** the rate register loads on the first accepted beat (start flag set after reset and after each tlast). s_axis_tuser on later beats is ignored.
- **Packer:** an accumulator of 2*OUT_WIDTH bits with a bit count.
  - New punctured bits are appended above the existing residue.
  - Whenever count ≥ OUT_WIDTH and the output register is free, the low OUT_WIDTH bits are emitted and the residue is shifted down.
- **History:** updated with the top 6 data bits of each beat. It clears to 0 after the tlast beat, so every packet starts from the zero state.
- **FSM states:**
  - RUN: accept beats and emit full words.
  - FLUSH: entered on acceptance of a tlast beat; s_axis_tready=0.
    - Emit full words while count > OUT_WIDTH.
    - Then emit the final word, zero-padded above the valid bits, with m_axis_tcount=count (1..OUT_WIDTH) and m_axis_tlast=1.
    - Then clear the accumulator and return to RUN.
- Because OUT_WIDTH ≥ 2*WIDTH, at most one word is emitted per accepted beat in RUN, so the residue never overflows.

## Timing
- **Reset values:** every output is 0 (tdata, tuser, tcount, tvalid, tlast, s_axis_tready). History, accumulator, count and rate clear to 0; state = RUN; start flag set.
  - Reset taking effect mid-packet or in FLUSH drops the partial packet. Outputs clear asynchronously.
- s_axis_tready = (state==RUN) && (!m_axis_tvalid || m_axis_tready).
- **Latency:** a word completed by a beat accepted in cycle n is valid in cycle n+1.
- FLUSH emits one word per cycle in which the output register is free; it takes 1 or 2 words.
- m_axis_tdata/tuser/tcount/tlast are held stable while tvalid && !tready.
- tvalid falls after a handshake unless a new word is loaded in the same cycle; back-to-back words are allowed.

## Configuration
- **CONV_ENC_TAIL_EN defined:**
  - On the tlast beat, 6 zero tail bits are encoded after the data bits, returning the encoder to state 0.
  - The tail is punctured at the packet rate: 12 / 9 / 8 bits for rates 1/2, 2/3, 3/4.
  - The tail bits are appended to the accumulator before FLUSH.
- **Not defined:** no tail bits; the final word holds only data-derived bits.

## Test plan
- **Rate 1/2, no tail:** `RATE_6M`, one beat 24'hFFFFFF with tlast.
  - One word with tcount=48, tlast=1.
  - First 12 bits in time order: 1,1,1,0,0,1,1,0,1,0,0,0; remaining 36 bits are all 1.
- **Rate 3/4, no tail:** `RATE_54M`, same input.
  - One word with tcount=32, tlast=1.
  - First 8 bits: 1,1,1,1,1,0,1,0; bits 8..31 are all 1; bits 32..47 are 0.
- **CONV_ENC_TAIL_EN, rate 1/2:** `RATE_6M`, same input.
  - Word 1: the 48 bits of the first scenario, tlast=0.
  - Word 2: tcount=12, tlast=1, bits 0,0,0,1,1,0,0,1,0,1,1,1.
- **Rate 2/3, two beats:** `RATE_48M` on beat 1, `RATE_6M` on beat 2 (must be ignored).
  - Word 1: tcount=48, tuser=`RATE_48M`.
  - Word 2: tcount=24, tlast=1.
- **Backpressure:** m_axis_tready held low for 10 cycles after the first word.
  - s_axis_tready=0 within 1 cycle; tdata stays stable; no bits are lost or duplicated versus the golden model.
- **Reset mid-FLUSH:** aresetn low for 1 cycle.
  - All outputs 0 immediately.
  - The next all-ones `RATE_6M` packet reproduces the first scenario exactly.

Source files
------------

// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct
//   K=7 convolutional encoder (generators G0/G1) with per-packet
//   puncturing at rate 1/2, 2/3 or 3/4, and a dense output bit packer.
//   Sits between the scrambler and the interleaver in the transmit chain.
//
// Ports
//   aclk, aresetn            clock (rising edge), asynchronous active-low reset
//   s_axis_tdata  [WIDTH]    scrambled data bits, bit 0 earliest in time
//   s_axis_tuser  [4]        rate code, sampled on the first beat of a packet
//   s_axis_tvalid/tready/tlast  input beat handshake
//   m_axis_tdata  [OUT_WIDTH] coded bits, bit 0 earliest, unused bits zero
//   m_axis_tuser  [4]        rate code latched for the packet
//   m_axis_tcount            number of valid bits in the word
//   m_axis_tvalid/tready/tlast  output word handshake
//
// Build option
//   CONV_ENC_TAIL_EN : when defined, six zero tail bits are encoded after the
//   last data bit of every packet and punctured at the packet rate.
module conv_encoder_punct #(
    parameter int         WIDTH     = 24,
    parameter int         OUT_WIDTH = 48,
    parameter logic [6:0] G0        = 7'o133,
    parameter logic [6:0] G1        = 7'o171
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [WIDTH-1:0]               s_axis_tdata,
    input  logic [3:0]                     s_axis_tuser,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [OUT_WIDTH-1:0]           m_axis_tdata,
    output logic [3:0]                     m_axis_tuser,
    output logic [$clog2(OUT_WIDTH+1)-1:0] m_axis_tcount,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL = 6;
`else
    localparam int TAIL = 0;
`endif
    localparam int NB    = WIDTH + TAIL;       // encoder steps per beat incl. tail
    localparam int PW    = 2 * NB;             // widest punctured vector
    // The tail beat can add 2*TAIL bits on top of a full residue, so the
    // accumulator carries that much headroom beyond two output words.
    localparam int ACC_W = 2 * OUT_WIDTH + 2 * TAIL;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int TC_W  = $clog2(OUT_WIDTH + 1);

    localparam logic [CNT_W-1:0] OW_CNT = CNT_W'(OUT_WIDTH);
    localparam logic [TC_W-1:0]  OW_TC  = TC_W'(OUT_WIDTH);

    // 802.11 SIGNAL-field rate codes that select a punctured rate;
    // every other code is coded at 1/2.
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_18M = 4'b1110;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;

    typedef enum logic {RUN, FLUSH} state_t;

    // 0 = 1/2, 1 = 2/3, 2 = 3/4
    function automatic logic [1:0] rate_class(input logic [3:0] code);
        case (code)
            RATE_48M:                              return 2'd1;
            RATE_9M, RATE_18M, RATE_36M, RATE_54M: return 2'd2;
            default:                               return 2'd0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] punct_len(input logic [1:0] cls, input logic with_tail);
        int n;
        n = with_tail ? NB : WIDTH;
        case (cls)
            2'd1:    return CNT_W'(3 * n / 2);
            2'd2:    return CNT_W'(4 * n / 3);
            default: return CNT_W'(2 * n);
        endcase
    endfunction

    state_t             state;
    logic               start;
    logic [3:0]         rate;
    logic [5:0]         hist;          // last 6 input bits, [5] most recent
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;

    logic               out_free, accept;
    logic [3:0]         rate_eff;
    logic [1:0]         cls_eff;
    logic [CNT_W-1:0]   add_len;
    logic [NB+5:0]      seq;
    logic [NB-1:0]      enc_a, enc_b;
    logic [PW-1:0]      pbits, pmask;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt_sum;
    logic               emit_full, emit_last;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = aresetn && (state == RUN) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    // The first beat of a packet is coded with its own tuser before it is latched.
    assign rate_eff      = (accept && start) ? s_axis_tuser : rate;
    assign cls_eff       = rate_class(rate_eff);
    // Without the tail build the tail argument changes nothing (NB == WIDTH).
    assign add_len       = punct_len(cls_eff, s_axis_tlast);
    assign pmask         = (PW'(1) << add_len) - PW'(1);

    // Encoder stage: seq holds history then data (then zero tail) in time
    // order, so the 7-bit window seq[i +: 7] has the current bit at [6].
    always_comb begin
        seq = '0;
        seq[WIDTH+5:0] = {s_axis_tdata, hist};
        enc_a = '0;
        enc_b = '0;
        for (int i = 0; i < NB; i++) begin
            enc_a[i] = ^(seq[i +: 7] & G0);
            enc_b[i] = ^(seq[i +: 7] & G1);
        end
        // Puncture phase restarts at bit 0 of each beat.
        pbits = '0;
        case (cls_eff)
            2'd1: begin
                for (int j = 0; j < NB / 2; j++) begin
                    pbits[3*j]   = enc_a[2*j];
                    pbits[3*j+1] = enc_b[2*j];
                    pbits[3*j+2] = enc_a[2*j+1];
                end
            end
            2'd2: begin
                for (int j = 0; j < NB / 3; j++) begin
                    pbits[4*j]   = enc_a[3*j];
                    pbits[4*j+1] = enc_b[3*j];
                    pbits[4*j+2] = enc_a[3*j+1];
                    pbits[4*j+3] = enc_b[3*j+2];
                end
            end
            default: begin
                for (int i = 0; i < NB; i++) begin
                    pbits[2*i]   = enc_a[i];
                    pbits[2*i+1] = enc_b[i];
                end
            end
        endcase
    end

    // Packer stage: append above the residue, then decide what to emit.
    always_comb begin
        acc_sum = acc;
        cnt_sum = count;
        if (accept) begin
            acc_sum = acc | (ACC_W'(pbits & pmask) << count);
            cnt_sum = count + add_len;
        end
        emit_full = 1'b0;
        emit_last = 1'b0;
        if (out_free) begin
            if (state == RUN)
                // On the tlast beat an exactly-full word is left for FLUSH so
                // that it goes out as the tlast word rather than a 0-bit tail.
                emit_full = (accept && s_axis_tlast) ? (cnt_sum > OW_CNT) : (cnt_sum >= OW_CNT);
            else if (count > OW_CNT)
                emit_full = 1'b1;
            else
                emit_last = 1'b1;
        end
    end

    // Output register stage
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= RUN;
            start         <= 1'b1;
            rate          <= '0;
            hist          <= '0;
            acc           <= '0;
            count         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tcount <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                if (start)
                    rate <= s_axis_tuser;
                start <= s_axis_tlast;
                hist  <= s_axis_tlast ? 6'd0 : s_axis_tdata[WIDTH-1 -: 6];
            end

            if (emit_full || emit_last) begin
                m_axis_tdata  <= acc_sum[OUT_WIDTH-1:0];
                m_axis_tuser  <= rate_eff;
                m_axis_tcount <= emit_last ? count[TC_W-1:0] : OW_TC;
                m_axis_tlast  <= emit_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (emit_last) begin
                acc   <= '0;
                count <= '0;
                state <= RUN;
            end else if (emit_full) begin
                acc   <= acc_sum >> OUT_WIDTH;
                count <= cnt_sum - OW_CNT;
            end else begin
                acc   <= acc_sum;
                count <= cnt_sum;
            end

            if (accept && s_axis_tlast)
                state <= FLUSH;
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
`timescale 1ns/1ps
module tb_conv_encoder_punct;

    localparam int WIDTH     = 24;
    localparam int OUT_WIDTH = 48;
    localparam int TCW       = $clog2(OUT_WIDTH + 1);
`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL_BITS = 6;
`else
    localparam int TAIL_BITS = 0;
`endif
    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    logic                 clk = 1'b0;
    logic                 aresetn = 1'b1;
    logic [WIDTH-1:0]     s_axis_tdata = '0;
    logic [3:0]           s_axis_tuser = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic                 s_axis_tlast = 1'b0;
    logic [OUT_WIDTH-1:0] m_axis_tdata;
    logic [3:0]           m_axis_tuser;
    logic [TCW-1:0]       m_axis_tcount;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b1;
    logic                 m_axis_tlast;

    int n_cmp = 0;
    int n_bad = 0;

    logic [OUT_WIDTH-1:0] q_data[$];
    logic [3:0]           q_user[$];
    logic [TCW-1:0]       q_cnt[$];
    logic                 q_last[$];

    always #5 clk = ~clk;

    conv_encoder_punct #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .G0(G0), .G1(G1)) dut (
        .aclk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tcount(m_axis_tcount), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    // Capture every word that will handshake at the coming rising edge.
    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_user.push_back(m_axis_tuser);
            q_cnt.push_back(m_axis_tcount);
            q_last.push_back(m_axis_tlast);
        end
    end

    task automatic clear_q();
        q_data.delete(); q_user.delete(); q_cnt.delete(); q_last.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l);
        bit got = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                #1;
                got = 1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL send_beat: accepted=0 required=1 (timeout)");
        end
    endtask

    task automatic wait_words(input string name, input int n);
        int c = 0;
        while (q_data.size() < n && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (5) begin @(posedge clk); #1; end
        n_cmp++;
        if (q_data.size() != n) begin
            n_bad++;
            $display("FAIL %s word_count: got %0d want %0d", name, q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 aresetn = 1'b0;
        #2;
        n_cmp++; if (m_axis_tdata  !== '0)   begin n_bad++; $display("FAIL reset tdata: got %h want 0", m_axis_tdata); end
        n_cmp++; if (m_axis_tuser  !== 4'd0) begin n_bad++; $display("FAIL reset tuser: got %h want 0", m_axis_tuser); end
        n_cmp++; if (m_axis_tcount !== '0)   begin n_bad++; $display("FAIL reset tcount: got %0d want 0", m_axis_tcount); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast  !== 1'b0) begin n_bad++; $display("FAIL reset tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL reset s_tready: got %b want 0", s_axis_tready); end
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rate_half(input string name);
        clear_q();
        send_beat(24'hFFFFFF, RATE_6M, 1'b1);
`ifdef CONV_ENC_TAIL_EN
        wait_words(name, 2);
        if (q_data.size() == 2) begin
            n_cmp++; if (q_last[0] !== 1'b0) begin n_bad++; $display("FAIL %s w0 tlast: got %b want 0", name, q_last[0]); end
            n_cmp++; if (q_cnt[1] !== 6'd12) begin n_bad++; $display("FAIL %s w1 tcount: got %0d want 12", name, q_cnt[1]); end
            n_cmp++; if (q_data[1] !== 48'h000000000E98) begin n_bad++; $display("FAIL %s w1 tdata: got %h want 000000000e98", name, q_data[1]); end
            n_cmp++; if (q_last[1] !== 1'b1) begin n_bad++; $display("FAIL %s w1 tlast: got %b want 1", name, q_last[1]); end
        end
`else
        wait_words(name, 1);
        if (q_data.size() == 1) begin
            n_cmp++; if (q_last[0] !== 1'b1) begin n_bad++; $display("FAIL %s w0 tlast: got %b want 1", name, q_last[0]); end
        end
`endif
        if (q_data.size() >= 1) begin
            n_cmp++; if (q_cnt[0] !== 6'd48) begin n_bad++; $display("FAIL %s w0 tcount: got %0d want 48", name, q_cnt[0]); end
            n_cmp++; if (q_data[0] !== 48'hFFFFFFFFF167) begin n_bad++; $display("FAIL %s w0 tdata: got %h want fffffffff167", name, q_data[0]); end
            n_cmp++; if (q_user[0] !== RATE_6M) begin n_bad++; $display("FAIL %s w0 tuser: got %h want %h", name, q_user[0], RATE_6M); end
        end
    endtask

    task automatic test_rate_three_quarter();
        logic [47:0]    exp_d;
        logic [TCW-1:0] exp_c;
`ifdef CONV_ENC_TAIL_EN
        exp_d = 48'h00A0FFFFFF5F; exp_c = 6'd40;
`else
        exp_d = 48'h0000FFFFFF5F; exp_c = 6'd32;
`endif
        clear_q();
        send_beat(24'hFFFFFF, RATE_54M, 1'b1);
        wait_words("r34", 1);
        if (q_data.size() == 1) begin
            n_cmp++; if (q_cnt[0] !== exp_c) begin n_bad++; $display("FAIL r34 tcount: got %0d want %0d", q_cnt[0], exp_c); end
            n_cmp++; if (q_data[0] !== exp_d) begin n_bad++; $display("FAIL r34 tdata: got %h want %h", q_data[0], exp_d); end
            n_cmp++; if (q_last[0] !== 1'b1) begin n_bad++; $display("FAIL r34 tlast: got %b want 1", q_last[0]); end
            n_cmp++; if (q_user[0] !== RATE_54M) begin n_bad++; $display("FAIL r34 tuser: got %h want %h", q_user[0], RATE_54M); end
        end
    endtask

    task automatic test_rate_two_thirds();
        logic [47:0]    exp_d;
        logic [TCW-1:0] exp_c;
`ifdef CONV_ENC_TAIL_EN
        exp_d = 48'h000188FFFFFF; exp_c = 6'd33;
`else
        exp_d = 48'h000000FFFFFF; exp_c = 6'd24;
`endif
        clear_q();
        send_beat(24'hFFFFFF, RATE_48M, 1'b0);
        send_beat(24'hFFFFFF, RATE_6M, 1'b1);
        // The word completed by the tlast beat is valid the next cycle.
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL r23 latency tvalid: got %b want 1", m_axis_tvalid); end
        wait_words("r23", 2);
        if (q_data.size() == 2) begin
            n_cmp++; if (q_cnt[0] !== 6'd48) begin n_bad++; $display("FAIL r23 w0 tcount: got %0d want 48", q_cnt[0]); end
            n_cmp++; if (q_data[0] !== 48'hFFFFFFFFFE77) begin n_bad++; $display("FAIL r23 w0 tdata: got %h want fffffffffe77", q_data[0]); end
            n_cmp++; if (q_user[0] !== RATE_48M) begin n_bad++; $display("FAIL r23 w0 tuser: got %h want %h", q_user[0], RATE_48M); end
            n_cmp++; if (q_last[0] !== 1'b0) begin n_bad++; $display("FAIL r23 w0 tlast: got %b want 0", q_last[0]); end
            n_cmp++; if (q_cnt[1] !== exp_c) begin n_bad++; $display("FAIL r23 w1 tcount: got %0d want %0d", q_cnt[1], exp_c); end
            n_cmp++; if (q_data[1] !== exp_d) begin n_bad++; $display("FAIL r23 w1 tdata: got %h want %h", q_data[1], exp_d); end
            n_cmp++; if (q_user[1] !== RATE_48M) begin n_bad++; $display("FAIL r23 w1 tuser: got %h want %h", q_user[1], RATE_48M); end
            n_cmp++; if (q_last[1] !== 1'b1) begin n_bad++; $display("FAIL r23 w1 tlast: got %b want 1", q_last[1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] bp [4];
        bit               exp_bits[$];
        bit               got_bits[$];
        logic [6:0]       sr;
        logic             in_b, a, b;
        logic [47:0]      cap;
        bit               seen;
        int               first_bad;
        bp[0] = 24'h5A3C96; bp[1] = 24'h0F1E2D; bp[2] = 24'hC3A5F0; bp[3] = 24'h123456;
        // Bit-serial reference: sr[6] is the current bit, sr[6-d] is d bits back.
        sr = '0;
        for (int k = 0; k < 4 * WIDTH + TAIL_BITS; k++) begin
            in_b = (k < 4 * WIDTH) ? bp[k / WIDTH][k % WIDTH] : 1'b0;
            sr = {in_b, sr[6:1]};
            a = ^(sr & G0);
            b = ^(sr & G1);
            case (k % 3)
                0:       begin exp_bits.push_back(a); exp_bits.push_back(b); end
                1:       exp_bits.push_back(a);
                default: exp_bits.push_back(b);
            endcase
        end

        clear_q();
        m_axis_tready = 1'b0;
        fork
            begin
                for (int j = 0; j < 4; j++) send_beat(bp[j], RATE_36M, j == 3);
            end
            begin
                seen = 0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (m_axis_tvalid) seen = 1;
                end
                n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp first_word: tvalid=0 want 1"); end
                n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp s_tready: got %b want 0", s_axis_tready); end
                cap = m_axis_tdata;
                repeat (10) begin
                    @(negedge clk);
                    n_cmp++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== cap) begin
                        n_bad++; $display("FAIL bp hold: tvalid=%b tdata=%h want 1 %h", m_axis_tvalid, m_axis_tdata, cap);
                    end
                    n_cmp++;
                    if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp stall s_tready: got %b want 0", s_axis_tready); end
                end
                @(posedge clk); #1;
                m_axis_tready = 1'b1;
            end
        join
        wait_words("bp", 3);
        for (int w = 0; w < q_data.size(); w++)
            for (int i = 0; i < int'(q_cnt[w]); i++) got_bits.push_back(q_data[w][i]);
        n_cmp++;
        if (got_bits.size() != exp_bits.size()) begin
            n_bad++; $display("FAIL bp bit_count: got %0d want %0d", got_bits.size(), exp_bits.size());
        end else begin
            first_bad = -1;
            for (int i = 0; i < exp_bits.size(); i++)
                if (got_bits[i] != exp_bits[i] && first_bad < 0) first_bad = i;
            if (first_bad >= 0) begin
                n_bad++; $display("FAIL bp bits: first differing bit %0d got %b want %b", first_bad, got_bits[first_bad], exp_bits[first_bad]);
            end
        end
        if (q_data.size() == 3) begin
            n_cmp++; if (q_last[0] !== 1'b0 || q_last[1] !== 1'b0 || q_last[2] !== 1'b1) begin
                n_bad++; $display("FAIL bp tlast: got %b%b%b want 001", q_last[0], q_last[1], q_last[2]);
            end
            n_cmp++; if (q_user[2] !== RATE_36M) begin n_bad++; $display("FAIL bp tuser: got %h want %h", q_user[2], RATE_36M); end
        end
    endtask

    task automatic test_reset_flush();
        clear_q();
        m_axis_tready = 1'b0;
        send_beat(24'hFFFFFF, RATE_48M, 1'b0);
        send_beat(24'hFFFFFF, RATE_6M, 1'b1);
        @(posedge clk); #1;
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL rflush stalled tvalid: got %b want 1", m_axis_tvalid); end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tdata !== '0 || m_axis_tuser !== 4'd0 || m_axis_tcount !== '0 ||
            m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL rflush outputs: tdata=%h tuser=%h tcount=%0d tvalid=%b tlast=%b s_tready=%b want all 0",
                     m_axis_tdata, m_axis_tuser, m_axis_tcount, m_axis_tvalid, m_axis_tlast, s_axis_tready);
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        test_rate_half("after_reset");
    endtask

    initial begin
        test_reset();
        test_rate_half("r12");
        repeat (3) begin @(posedge clk); #1; end
        test_rate_three_quarter();
        repeat (3) begin @(posedge clk); #1; end
        test_rate_two_thirds();
        repeat (3) begin @(posedge clk); #1; end
        test_backpressure();
        repeat (3) begin @(posedge clk); #1; end
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
